dec2to4_strobe: RTL and testbench
=================================

# dec2to4_strobe

Sequential 2-to-4 decoder, the inverse of the 4-to-2 priority encoder. It accepts a 2-bit code through a valid/ready handshake and drives the matching one-hot line `d` for a fixed number of cycles, followed by an optional idle gap. A one-entry pending buffer lets the upstream issue the next code while a strobe is still running. It sits between control logic that produces encoded select codes and downstream blocks that need timed one-hot enables.

## Interface
- `HOLD`, default 4: cycles each one-hot strobe stays asserted; legal range ≥1.
- `GAP`, default 1: zero cycles forced on `d` after each strobe; legal range ≥0.
- `CW`, default `$clog2(max(HOLD,GAP)+1)`: internal counter width; derived, not overridden.

- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: synchronous enable; when low, the block flushes and holds idle.
- `in_valid` input 1: a code is present on `a`.
- `a` input 2: code to decode; 0→`d`=0001, 1→0010, 2→0100, 3→1000.
- `in_ready` output 1: the block can accept a code this cycle.
- `d` output 4: one-hot strobe, all-zero outside strobes.
- `busy` output 1: state is not IDLE, or the pending buffer is full.
- `done` output 1: one-cycle pulse on the last cycle of each strobe.

## Operation
- **Reset values** (async, while `rst_n`=0): state=IDLE, pending empty, counter=0, `d`=0000, `done`=0, `busy`=0, `in_ready`=0. `in_ready` rises in the first cycle after reset release if `en`=1.
- **States:**
  - IDLE: `d`=0.
  - PULSE: `d`=onehot(code), counter counts HOLD cycles.
  - GAP: `d`=0, counter counts GAP cycles; never entered when GAP=0.
- **Handshake:**
  - `in_ready` = `en` & pending empty.
  - Accept = `in_valid` & `in_ready` at a rising edge.
  - `a` is sampled only on accept.
  - The upstream holds `a` and `in_valid` stable until accepted.
- **Accept in IDLE:** load the code, go to PULSE, counter=HOLD-1.
- **Accept in PULSE or GAP:** store the code in the pending buffer.
  - Exception: if this is the terminal cycle and pending is empty, the code goes straight into the next PULSE.
- **Terminal cycle:** PULSE with counter=0 when GAP=0, otherwise GAP with counter=0.
  - Next code source: pending if full, else the code accepted this cycle, else none.
  - With a next code: go to PULSE, reload HOLD-1, clear pending.
  - Without a next code: go to IDLE.
- **PULSE with counter=0 and GAP>0:** assert `done`, go to GAP with counter=GAP-1.
- **`done`:** asserted in the last PULSE cycle for every strobe, including back-to-back strobes.
- **`en`=0 (synchronous flush):**
  - Next state IDLE, pending cleared, `d`=0 from the next cycle on.
  - `in_ready`=0 combinationally.
  - No `done` pulse is issued for the truncated strobe.
- **Reset mid-strobe:** `d` drops to 0 immediately (asynchronously), and the pending code is lost.
- **Counters:** wrap-free; reload values are truncated to CW bits.

## Timing
- Latency: accept at edge k → `d` one-hot during cycles k+1 … k+HOLD.
- After the strobe, `d`=0 during cycles k+HOLD+1 … k+HOLD+GAP.
- If a code is ready back-to-back, the next strobe starts at cycle k+HOLD+GAP+1.
- With GAP=0, `d` switches directly from one one-hot value to the next with no zero cycle.
- Sustained throughput: one code per HOLD+GAP cycles.
- `in_ready`:
  - Combinational from `en` and registered pending state.
  - Falls the cycle after a code lands in pending.
  - Rises the cycle after pending is consumed.
- `d`, `done` and `busy` are registered or derived from registered state only; there is no combinational path from `a` or `in_valid` to `d`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `in_valid`=1 → `d`=0000, `done`=0, `busy`=0. Release with `en`=1 → first accept occurs at the next edge.
- **Single code, default parameters:** `a`=2 accepted at edge 10 → `d`=0100 for cycles 11–14, `done` high in cycle 14, `d`=0 in cycle 15, IDLE in cycle 16, `busy` low from cycle 16.
- **Buffered back-to-back:** accept `a`=1 at edge 10, then `a`=3 at edge 12 → `in_ready`=0 for cycles 13–15. Expect `d`=0010 for cycles 11–14, 0 in cycle 15, 1000 for cycles 16–19, and exactly two `done` pulses (cycles 14 and 19).
- **GAP=0, HOLD=1:** stream codes 0,1,2,3 with `in_valid` held high → `d` = 0001, 0010, 0100, 1000 in consecutive cycles, `done` high in each, no zero cycle in between.
- **Terminal-cycle accept:** with pending empty, accept `a`=0 in the last GAP cycle → `d`=0001 starts in the next cycle, and the pending buffer is never used.
- **Flush:** drop `en` in the 2nd cycle of a strobe with a code pending → `d`=0 from the next cycle, no `done`, pending discarded. Raise `en` again → IDLE with `busy`=0.

Source files
------------

// File: rtl/dec2to4_strobe_if.sv
// Handshake and strobe bundle for dec2to4_strobe: code input side plus
// one-hot strobe/status output side.
interface dec2to4_strobe_if;
   logic       en;
   logic       in_valid;
   logic [1:0] a;
   logic       in_ready;
   logic [3:0] d;
   logic       busy;
   logic       done;

   modport master (
      output en,
      output in_valid,
      output a,
      input  in_ready,
      input  d,
      input  busy,
      input  done
   );

   modport slave (
      input  en,
      input  in_valid,
      input  a,
      output in_ready,
      output d,
      output busy,
      output done
   );
endinterface

// File: rtl/dec2to4_strobe.sv
// Sequential 2-to-4 decoder: accepts a 2-bit code by valid/ready and drives a
// timed one-hot strobe, with an optional idle gap and a one-entry pending slot.
module dec2to4_strobe #(
   parameter int HOLD = 4,
   parameter int GAP  = 1,
   parameter int CW   = $clog2(((HOLD > GAP) ? HOLD : GAP) + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   dec2to4_strobe_if.slave   bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic          GAP_EN_C  = (GAP > 0);
   localparam logic [CW-1:0] HOLD_LD_C = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LD_C  = CW'((GAP > 0) ? (GAP - 1) : 0);

   function automatic logic [3:0] onehot(input logic [1:0] code);
      logic [3:0] res;
      case (code)
         2'd0:    res = 4'b0001;
         2'd1:    res = 4'b0010;
         2'd2:    res = 4'b0100;
         2'd3:    res = 4'b1000;
         default: res = 4'b0000;
      endcase
      return res;
   endfunction

   logic [1:0]    state_r;
   logic [CW-1:0] cnt_r;
   logic [1:0]    code_r;
   logic          pend_vld_r;
   logic [1:0]    pend_code_r;
   logic [3:0]    d_r;
   logic          done_r;
   logic          busy_r;

   logic [1:0]    state_nxt_s;
   logic [CW-1:0] cnt_nxt_s;
   logic [1:0]    code_nxt_s;
   logic          pend_vld_nxt_s;
   logic [1:0]    pend_code_nxt_s;
   logic          ready_s;
   logic          accept_s;
   logic          term_s;

   // rst_n gates ready so it is low during reset yet a code can be taken on
   // the very first edge after release.
   assign ready_s  = bus.en & ~pend_vld_r & rst_n;
   assign accept_s = bus.in_valid & ready_s;

   // Terminal cycle: last PULSE cycle when there is no gap, else last GAP cycle.
   assign term_s = ((state_r == ST_PULSE) && (cnt_r == '0) && !GAP_EN_C) ||
                   ((state_r == ST_GAP)   && (cnt_r == '0));

   // Next-state, counter and pending-slot logic.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      code_nxt_s      = code_r;
      pend_vld_nxt_s  = pend_vld_r;
      pend_code_nxt_s = pend_code_r;
      if (!bus.en) begin
         state_nxt_s    = ST_IDLE;
         cnt_nxt_s      = '0;
         pend_vld_nxt_s = 1'b0;
      end else if (term_s) begin
         // Pending code has priority; in_ready is low whenever it is full.
         if (pend_vld_r) begin
            state_nxt_s    = ST_PULSE;
            cnt_nxt_s      = HOLD_LD_C;
            code_nxt_s     = pend_code_r;
            pend_vld_nxt_s = 1'b0;
         end else if (accept_s) begin
            state_nxt_s = ST_PULSE;
            cnt_nxt_s   = HOLD_LD_C;
            code_nxt_s  = bus.a;
         end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_nxt_s = ST_PULSE;
                  cnt_nxt_s   = HOLD_LD_C;
                  code_nxt_s  = bus.a;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_PULSE: begin
               if (cnt_r != '0) begin
                  cnt_nxt_s = cnt_r - CW'(1);
               end else begin
                  state_nxt_s = ST_GAP;
                  cnt_nxt_s   = GAP_LD_C;
               end
               if (accept_s) begin
                  pend_vld_nxt_s  = 1'b1;
                  pend_code_nxt_s = bus.a;
               end else begin
                  pend_vld_nxt_s  = pend_vld_r;
               end
            end
            ST_GAP: begin
               cnt_nxt_s = cnt_r - CW'(1);
               if (accept_s) begin
                  pend_vld_nxt_s  = 1'b1;
                  pend_code_nxt_s = bus.a;
               end else begin
                  pend_vld_nxt_s  = pend_vld_r;
               end
            end
            default: begin
               state_nxt_s    = ST_IDLE;
               cnt_nxt_s      = '0;
               pend_vld_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs, all computed from next-state values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         code_r      <= 2'd0;
         pend_vld_r  <= 1'b0;
         pend_code_r <= 2'd0;
         d_r         <= 4'b0000;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         code_r      <= code_nxt_s;
         pend_vld_r  <= pend_vld_nxt_s;
         pend_code_r <= pend_code_nxt_s;
         d_r         <= (state_nxt_s == ST_PULSE) ? onehot(code_nxt_s) : 4'b0000;
         done_r      <= (state_nxt_s == ST_PULSE) && (cnt_nxt_s == '0);
         busy_r      <= (state_nxt_s != ST_IDLE) || pend_vld_nxt_s;
      end
   end

   assign bus.in_ready = ready_s;
   assign bus.d        = d_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_dec2to4_strobe.sv
// Table-driven bench for dec2to4_strobe: a default-parameter instance and a
// HOLD=1/GAP=0 instance, plus hand-written reset sequences.
module tb_dec2to4_strobe;

   logic clk;
   logic rst_n;

   dec2to4_strobe_if bus0 ();
   dec2to4_strobe_if bus1 ();

   dec2to4_strobe #(.HOLD(4), .GAP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   dec2to4_strobe #(.HOLD(1), .GAP(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic       en;
      logic       vld;
      logic [1:0] a;
      logic [3:0] d;
      logic       done;
      logic       busy;
      logic       rdy;
   } row_t;

   row_t rows[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic void add(int sel, int en, int vld, int a, int d,
                               int done, int busy, int rdy);
      row_t r;
      r.sel  = sel[0];
      r.en   = en[0];
      r.vld  = vld[0];
      r.a    = a[1:0];
      r.d    = d[3:0];
      r.done = done[0];
      r.busy = busy[0];
      r.rdy  = rdy[0];
      rows.push_back(r);
   endfunction

   task automatic chk(input string nm, input int row, input logic [3:0] act,
                      input logic [3:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: actual %b required %b", nm, row, act, exp);
   endtask

   initial begin
      // single code a=2, default HOLD=4 GAP=1
      add(0,1,1,2, 4'b0000,0,0,1);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 4'b0100,0,1,1);
      add(0,1,0,0, 4'b0100,1,1,1);
      add(0,1,0,0, 4'b0000,0,1,1);
      add(0,1,0,0, 4'b0000,0,0,1);
      // buffered back-to-back: a=1 then a=3 two cycles later
      add(0,1,1,1, 4'b0000,0,0,1);
      add(0,1,0,0, 4'b0010,0,1,1);
      add(0,1,1,3, 4'b0010,0,1,1);
      add(0,1,0,0, 4'b0010,0,1,0);
      add(0,1,0,0, 4'b0010,1,1,0);
      add(0,1,0,0, 4'b0000,0,1,0);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 4'b1000,0,1,1);
      add(0,1,0,0, 4'b1000,1,1,1);
      add(0,1,0,0, 4'b0000,0,1,1);
      add(0,1,0,0, 4'b0000,0,0,1);
      // terminal-cycle accept of a=0 in the last gap cycle
      add(0,1,1,2, 4'b0000,0,0,1);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 4'b0100,0,1,1);
      add(0,1,0,0, 4'b0100,1,1,1);
      add(0,1,1,0, 4'b0000,0,1,1);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 4'b0001,0,1,1);
      add(0,1,0,0, 4'b0001,1,1,1);
      add(0,1,0,0, 4'b0000,0,1,1);
      add(0,1,0,0, 4'b0000,0,0,1);
      // flush in the 2nd strobe cycle with a=3 pending
      add(0,1,1,1, 4'b0000,0,0,1);
      add(0,1,1,3, 4'b0010,0,1,1);
      add(0,0,0,0, 4'b0010,0,1,0);
      add(0,0,0,0, 4'b0000,0,0,0);
      add(0,0,0,0, 4'b0000,0,0,0);
      for (int i = 0; i < 4; i++) add(0,1,0,0, 4'b0000,0,0,1);
      // HOLD=1 GAP=0 stream of 0,1,2,3
      add(1,1,1,0, 4'b0000,0,0,1);
      add(1,1,1,1, 4'b0001,1,1,1);
      add(1,1,1,2, 4'b0010,1,1,1);
      add(1,1,1,3, 4'b0100,1,1,1);
      add(1,1,0,0, 4'b1000,1,1,1);
      add(1,1,0,0, 4'b0000,0,0,1);

      // reset held 3 cycles with in_valid high
      rst_n = 1'b0;
      bus0.en = 1'b1; bus0.in_valid = 1'b1; bus0.a = 2'd3;
      bus1.en = 1'b1; bus1.in_valid = 1'b0; bus1.a = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_d",    i, bus0.d, 4'b0000);
         chk("rst_done", i, {3'b000, bus0.done}, 4'b0000);
         chk("rst_busy", i, {3'b000, bus0.busy}, 4'b0000);
         chk("rst_rdy",  i, {3'b000, bus0.in_ready}, 4'b0000);
      end
      rst_n = 1'b1;
      #1 chk("rel_rdy", 0, {3'b000, bus0.in_ready}, 4'b0001);
      @(posedge clk); #1;
      chk("rel_accept_d", 0, bus0.d, 4'b1000);
      bus0.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_strobe_d", 0, bus0.d, 4'b1000);
      // asynchronous reset in the middle of the strobe
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_d",    0, bus0.d, 4'b0000);
      chk("async_rst_busy", 0, {3'b000, bus0.busy}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (rows[i]) begin
         @(posedge clk); #1;
         if (rows[i].sel) begin
            bus1.en = rows[i].en; bus1.in_valid = rows[i].vld; bus1.a = rows[i].a;
            bus0.en = 1'b1;       bus0.in_valid = 1'b0;        bus0.a = 2'd0;
         end else begin
            bus0.en = rows[i].en; bus0.in_valid = rows[i].vld; bus0.a = rows[i].a;
            bus1.en = 1'b1;       bus1.in_valid = 1'b0;        bus1.a = 2'd0;
         end
         @(negedge clk);
         if (rows[i].sel) begin
            chk("g0_d",    i, bus1.d, rows[i].d);
            chk("g0_done", i, {3'b000, bus1.done}, {3'b000, rows[i].done});
            chk("g0_busy", i, {3'b000, bus1.busy}, {3'b000, rows[i].busy});
            chk("g0_rdy",  i, {3'b000, bus1.in_ready}, {3'b000, rows[i].rdy});
         end else begin
            chk("d",    i, bus0.d, rows[i].d);
            chk("done", i, {3'b000, bus0.done}, {3'b000, rows[i].done});
            chk("busy", i, {3'b000, bus0.busy}, {3'b000, rows[i].busy});
            chk("rdy",  i, {3'b000, bus0.in_ready}, {3'b000, rows[i].rdy});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
